dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Memory-stage consumer of the pipelined core's data-side outputs (ALUResultM, WriteDataM, MemWriteM, funct3M).
//  Returns ReadDataM in the same cycle.
//  Contains the byte-addressed data RAM, which does byte-lane store steering and load sign/zero extension.
//  Also holds a small MMIO window: GPIO register, cycle counter, and a TX byte FIFO with a valid/ready drain port.
// PARAMETERS
//  RAM_WORDS   256  data RAM depth in 32-bit words (power of 2); RAM decoded at 0x0000_0000
//  FIFO_DEPTH  8    TX FIFO entries (power of 2, 2..16)
//  MMIO_BASE   32'h1000_0000  base of MMIO window; the upper 28 address bits select the window
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   synchronous, active-high
//  MemWriteM   in   1   store strobe from the M stage
//  funct3M     in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ALUResultM  in   32  byte address
//  WriteDataM  in   32  store data; the low bytes are used for B/H
//  ReadDataM   out  32  load data, combinational, already extended
//  gpio_out    out  32  GPIO register
//  tx_data     out  8   FIFO head byte
//  tx_valid    out  1   FIFO non-empty
//  tx_ready    in   1   consumer accepts head when tx_valid & tx_ready
//  mem_err     out  1   sticky error flag: misaligned or illegal store
// BEHAVIOUR
//  Reset values:
//   - gpio_out=0, FIFO empty, tx_valid=0, tx_data=0, cycle=0, overflow=0, mem_err=0.
//   - RAM contents are not reset.
//  Reads:
//   - Combinational and side-effect free; a read never pops the FIFO or clears the counter.
//   - B/H select lanes from addr[1:0]. B/H sign-extend; BU/HU zero-extend.
//   - Reads from unmapped addresses return 0.
//  Stores:
//   - Written on the rising edge when MemWriteM=1.
//   - SB writes lane addr[1:0]; SH writes lanes {addr[1],0}+{0,1}; SW writes all four lanes.
//  Alignment:
//   - SH with addr[0]=1, SW with addr[1:0]!=0, or a store funct3 outside {000,001,010}: the store is suppressed and mem_err is set on the next edge.
//   - Misaligned loads return the naturally aligned data (low address bits ignored) and also set mem_err.
//   - Because there is no read strobe, mem_err is set for any cycle whose address/funct3 is misaligned for a load.
//  MMIO map (offsets from MMIO_BASE, word access only; B/H stores to MMIO are suppressed and set mem_err):
//   +0x0 GPIO    RW: the write replaces gpio_out on the next edge.
//   +0x4 TXDATA  W: the write pushes WriteDataM[7:0]; reads return 0.
//   +0x8 TXSTAT  R: [0]=full, [1]=empty, [2]=overflow (sticky), [8:4]=count.
//                W: any write clears overflow.
//   +0xC CYCLE   R: free-running 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF->0.
//                W: the write loads 0 (the counter reads 1 the cycle after).
//  FIFO:
//   - Pop occurs on the edge where tx_valid & tx_ready.
//   - Push when full with no simultaneous pop: data dropped, overflow set, count unchanged.
//   - Push and pop in the same cycle: both occur. When full this is accepted (count unchanged); when count=1, the new byte becomes the head.
//   - tx_data/tx_valid come from registered state (head pointer into the array); tx_data is held stable while tx_valid & !tx_ready.
//   - Pointers are log2(FIFO_DEPTH) bits and wrap; count is a separate register, 0..FIFO_DEPTH.
//  Reset mid-operation: FIFO contents discarded, pointers and count zeroed; a pending store in the reset cycle is not performed.
//  Address decode: RAM index = addr[log2(RAM_WORDS)+1:2]; RAM hit only if higher bits are 0; otherwise unmapped (stores ignored, no error).
// STRUCTURE
//  Shared package dmem_pkg:
//   - funct3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
//   - MMIO_BASE and offsets (OFF_GPIO, OFF_TXDATA, OFF_TXSTAT, OFF_CYCLE).
//   - TXSTAT bit positions.
//  One sub-module, tx_fifo: parameterised DEPTH and width 8, push/pop/full/empty/count/overflow.
//  The byte-lane steering and load extension stay inline in dmem_lsu.
// TESTING
//  1. SW 0xDEADBEEF @0x10; LB @0x13 -> ReadDataM=0xFFFFFFDE; LBU @0x10 -> 0x000000EF; LH @0x12 -> 0xFFFFDEAD.
//  2. SB 0x5A @0x11 over 0x11223344 -> LW @0x10 = 0x11225A44. SH 0xBEEF @0x13 -> no write, mem_err=1 next cycle.
//  3. Push 9 bytes 0x01..0x09 with tx_ready=0 (FIFO_DEPTH=8) -> TXSTAT full=1, overflow=1, count=8.
//     Then tx_ready=1 -> tx_data 0x01..0x08 in order, one per cycle; then empty=1, tx_valid=0.
//  4. FIFO full and push 0xAA while tx_ready=1 -> count stays 8; 0xAA is drained last; overflow not set.
//  5. Write CYCLE; read next cycle -> 1. Preload 0xFFFFFFFF via reset-free run or force -> wraps to 0.
//  6. Assert reset mid-drain with count=5 plus a concurrent SW to GPIO -> next cycle tx_valid=0, count=0, gpio_out=0, mem_err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 access codes,
// MMIO window layout and TXSTAT bit positions.
package dmem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

    localparam logic [3:0] OFF_GPIO   = 4'h0;
    localparam logic [3:0] OFF_TXDATA = 4'h4;
    localparam logic [3:0] OFF_TXSTAT = 4'h8;
    localparam logic [3:0] OFF_CYCLE  = 4'hC;

    localparam int unsigned TS_FULL    = 0;
    localparam int unsigned TS_EMPTY   = 1;
    localparam int unsigned TS_OVF     = 2;
    localparam int unsigned TS_CNT_LSB = 4;
    localparam int unsigned TS_CNT_W   = 5;

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide transmit FIFO with registered head output, separate occupancy
// counter and a sticky overflow flag for pushes dropped while full.
module tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    input  logic                     clr_ovf,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // count never exceeds DEPTH, so its MSB alone marks full
    assign full    = count[PW];
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (clr_ovf)
                overflow <= 1'b0;
            else if (push & full & ~do_pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Memory-stage data RAM with byte-lane store steering, load extension and an
// MMIO window (GPIO, cycle counter, TX FIFO); loads are combinational.
module dmem_lsu #(
    parameter int unsigned RAM_WORDS  = 256,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = dmem_pkg::MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic [31:0] gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_err
);

    import dmem_pkg::*;

    localparam int unsigned IW = $clog2(RAM_WORDS);

    logic [31:0]             ram [RAM_WORDS];
    logic [IW-1:0]           idx;
    logic [1:0]              lane;
    logic [3:0]              off;
    logic                    ram_hit, mmio_hit;
    logic                    ld_mis, st_legal, word_acc;
    logic                    store_ok, ram_we, mmio_we, err_set;
    logic [3:0]              be;
    logic [31:0]             wlanes;
    logic [31:0]             rword, stat, cycle;
    logic [7:0]              bsel;
    logic [15:0]             hsel;
    logic                    fifo_full, fifo_empty, fifo_ovf;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign idx      = ALUResultM[IW+1:2];
    assign lane     = ALUResultM[1:0];
    assign off      = ALUResultM[3:0];
    assign ram_hit  = (ALUResultM[31:IW+2] == '0);
    assign mmio_hit = (ALUResultM[31:4] == MMIO_BASE[31:4]);
    assign word_acc = (funct3M == F3_W);

    always_comb begin
        ld_mis   = 1'b0;
        st_legal = 1'b0;
        be       = '0;
        wlanes   = WriteDataM;
        case (funct3M)
            F3_B: begin
                st_legal = 1'b1;
                be       = 4'b0001 << lane;
                wlanes   = {4{WriteDataM[7:0]}};
            end
            F3_H: begin
                ld_mis   = lane[0];
                st_legal = ~lane[0];
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{WriteDataM[15:0]}};
            end
            F3_HU:   ld_mis = lane[0];
            F3_W: begin
                ld_mis   = |lane;
                st_legal = ~|lane;
                be       = 4'b1111;
            end
            default: ;
        endcase
    end

    // MMIO registers only accept aligned word stores
    assign store_ok = MemWriteM & st_legal & (~mmio_hit | word_acc);
    assign ram_we   = store_ok & ram_hit & ~reset;
    assign mmio_we  = store_ok & mmio_hit;
    assign err_set  = ld_mis | (MemWriteM & (~st_legal | (mmio_hit & ~word_acc)));

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned b = 0; b < 4; b++)
                if (be[b]) ram[idx][8*b +: 8] <= wlanes[8*b +: 8];
        end
    end

    // A CYCLE write zeroes the count for the current cycle, so it reads 1 next
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out <= '0;
            cycle    <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (mmio_we && off == OFF_GPIO) gpio_out <= WriteDataM;
            cycle <= (mmio_we && off == OFF_CYCLE) ? 32'd1 : cycle + 32'd1;
            if (err_set) mem_err <= 1'b1;
        end
    end

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (mmio_we && off == OFF_TXDATA),
        .din      (WriteDataM[7:0]),
        .pop      (tx_valid & tx_ready),
        .clr_ovf  (mmio_we && off == OFF_TXSTAT),
        .dout     (tx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_ovf)
    );

    assign tx_valid = ~fifo_empty;

    always_comb begin
        stat                            = '0;
        stat[TS_FULL]                   = fifo_full;
        stat[TS_EMPTY]                  = fifo_empty;
        stat[TS_OVF]                    = fifo_ovf;
        stat[TS_CNT_LSB +: TS_CNT_W]    = TS_CNT_W'(fifo_count);
    end

    always_comb begin
        rword = '0;
        if (ram_hit) begin
            rword = ram[idx];
        end else if (mmio_hit) begin
            case (off[3:2])
                OFF_GPIO[3:2]:   rword = gpio_out;
                OFF_TXSTAT[3:2]: rword = stat;
                OFF_CYCLE[3:2]:  rword = cycle;
                default:         rword = '0;
            endcase
        end
    end

    assign bsel = rword[{lane, 3'b000} +: 8];
    assign hsel = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (funct3M)
            F3_B:    ReadDataM = {{24{bsel[7]}}, bsel};
            F3_BU:   ReadDataM = {24'h0, bsel};
            F3_H:    ReadDataM = {{16{hsel[15]}}, hsel};
            F3_HU:   ReadDataM = {16'h0, hsel};
            default: ReadDataM = rword;
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: RAM loads/stores, alignment errors,
// TX FIFO overflow and full push/pop, cycle counter and mid-drain reset.
module tb_dmem_lsu;

    import dmem_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [31:0] gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  tx_q  [$];

    always #5 clk = ~clk;

    dmem_lsu #(.RAM_WORDS(256), .FIFO_DEPTH(8), .MMIO_BASE(32'h1000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .gpio_out   (gpio_out),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .mem_err    (mem_err)
    );

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy);
        @(negedge clk);
        MemWriteM  = we;
        funct3M    = f3;
        ALUResultM = a;
        WriteDataM = d;
        tx_ready   = rdy;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, F3_W, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset = 1'b1;
        drive(1'b0, F3_W, 32'h0, 32'h0, 1'b0);
        drive(1'b0, F3_W, BASE + 32'h8, 32'h0, 1'b0);
        n_tests++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL rst_gpio got %h exp 0", gpio_out); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
        n_tests++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL rst_tx_data got %h exp 0", tx_data); end
        n_tests++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL rst_mem_err got %b exp 0", mem_err); end
        exp_q.push_back(32'h0000_0002);
        e = exp_q.pop_front();
        n_tests++; if (ReadDataM !== e) begin n_fail++; $display("FAIL rst_txstat got %h exp %h", ReadDataM, e); end
        exp_q.push_back(32'h0);
        drive(1'b0, F3_W, BASE + 32'hC, 32'h0, 1'b0);
        e = exp_q.pop_front();
        n_tests++; if (ReadDataM !== e) begin n_fail++; $display("FAIL rst_cycle got %h exp %h", ReadDataM, e); end
        reset = 1'b0;
    endtask

    task automatic test_ram_loads();
        logic [31:0] la [10] = '{32'h13, 32'h10, 32'h12, 32'h10, 32'h12, 32'h11,
                                 32'h0, 32'h3FC, 32'h400, 32'h2000_0000};
        logic [2:0]  lf [10] = '{F3_B, F3_BU, F3_H, F3_W, F3_HU, F3_B, F3_W, F3_W, F3_W, F3_W};
        logic [31:0] le [10] = '{32'hFFFF_FFDE, 32'h0000_00EF, 32'hFFFF_DEAD, 32'hDEAD_BEEF,
                                 32'h0000_DEAD, 32'hFFFF_FFBE, 32'h1111_1111, 32'h3333_3333,
                                 32'h0, 32'h0};
        logic [31:0] e;
        drive(1'b1, F3_W, 32'h10,  32'hDEAD_BEEF, 1'b0);
        drive(1'b1, F3_W, 32'h0,   32'h1111_1111, 1'b0);
        drive(1'b1, F3_W, 32'h3FC, 32'h3333_3333, 1'b0);
        drive(1'b1, F3_W, 32'h400, 32'h2222_2222, 1'b0);
        drive(1'b1, F3_W, 32'h2000_0000, 32'h4444_4444, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(le[i]);
            drive(1'b0, lf[i], la[i], 32'h0, 1'b0);
            e = exp_q.pop_front();
            n_tests++;
            if (ReadDataM !== e) begin
                n_fail++; $display("FAIL load_%0d addr %h got %h exp %h", i, la[i], ReadDataM, e);
            end
        end
        n_tests++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL ram_no_err got %b exp 0", mem_err); end
    endtask

    task automatic test_store_steer();
        drive(1'b1, F3_W, 32'h10, 32'h1122_3344, 1'b0);
        drive(1'b1, F3_B, 32'h11, 32'hFFFF_FF5A, 1'b0);
        drive(1'b0, F3_W, 32'h10, 32'h0, 1'b0);
        n_tests++; if (ReadDataM !== 32'h1122_5A44) begin n_fail++; $display("FAIL sb_lane1 got %h exp 11225a44", ReadDataM); end
        drive(1'b1, F3_H, 32'h12, 32'hCAFE_BEEF, 1'b0);
        drive(1'b0, F3_W, 32'h10, 32'h0, 1'b0);
        n_tests++; if (ReadDataM !== 32'hBEEF_5A44) begin n_fail++; $display("FAIL sh_upper got %h exp beef5a44", ReadDataM); end
        n_tests++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL sh_aligned_err got %b exp 0", mem_err); end
        drive(1'b1, F3_H, 32'h13, 32'h0000_1234, 1'b0);
        drive(1'b0, F3_W, 32'h10, 32'h0, 1'b0);
        n_tests++; if (ReadDataM !== 32'hBEEF_5A44) begin n_fail++; $display("FAIL sh_mis_suppr got %h exp beef5a44", ReadDataM); end
        n_tests++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL sh_mis_err got %b exp 1", mem_err); end
        do_reset();
        drive(1'b0, F3_W, 32'h12, 32'h0, 1'b0);
        n_tests++; if (ReadDataM !== 32'hBEEF_5A44) begin n_fail++; $display("FAIL lw_mis_data got %h exp beef5a44", ReadDataM); end
        drive(1'b0, F3_W, 32'h0, 32'h0, 1'b0);
        n_tests++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL lw_mis_err got %b exp 1", mem_err); end
        do_reset();
        drive(1'b1, F3_B, BASE, 32'h0000_00FF, 1'b0);
        drive(1'b0, F3_W, 32'h0, 32'h0, 1'b0);
        n_tests++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL sb_mmio_suppr got %h exp 0", gpio_out); end
        n_tests++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL sb_mmio_err got %b exp 1", mem_err); end
        do_reset();
        drive(1'b1, F3_W, 32'h20, 32'h0, 1'b0);
        drive(1'b1, 3'b100, 32'h20, 32'hFFFF_FFFF, 1'b0);
        drive(1'b0, F3_W, 32'h20, 32'h0, 1'b0);
        n_tests++; if (ReadDataM !== 32'h0) begin n_fail++; $display("FAIL st_bad_f3_suppr got %h exp 0", ReadDataM); end
        n_tests++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL st_bad_f3_err got %b exp 1", mem_err); end
        do_reset();
    endtask

    task automatic test_fifo_overflow();
        logic [7:0] e8;
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, F3_W, BASE + 32'h4, 32'(i), 1'b0);
            if (tx_q.size() < 8) tx_q.push_back(8'(i));
        end
        drive(1'b0, F3_W, BASE + 32'h8, 32'h0, 1'b0);
        n_tests++; if (ReadDataM !== 32'h0000_0085) begin n_fail++; $display("FAIL ovf_txstat got %h exp 00000085", ReadDataM); end
        drive(1'b0, F3_W, BASE + 32'h4, 32'h0, 1'b0);
        n_tests++; if (ReadDataM !== 32'h0) begin n_fail++; $display("FAIL txdata_read got %h exp 0", ReadDataM); end
        n_tests++; if (tx_data !== 8'h01) begin n_fail++; $display("FAIL head_held got %h exp 01", tx_data); end
        for (int c = 0; c < 20 && tx_q.size() > 0; c++) begin
            drive(1'b0, F3_W, 32'h0, 32'h0, 1'b1);
            if (tx_valid) begin
                e8 = tx_q.pop_front();
                n_tests++;
                if (tx_data !== e8) begin n_fail++; $display("FAIL ovf_drain got %h exp %h", tx_data, e8); end
            end
        end
        n_tests++; if (tx_q.size() != 0) begin n_fail++; $display("FAIL ovf_drain_timeout left %0d exp 0", tx_q.size()); end
        drive(1'b0, F3_W, BASE + 32'h8, 32'h0, 1'b0);
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty_valid got %b exp 0", tx_valid); end
        n_tests++; if (ReadDataM !== 32'h0000_0006) begin n_fail++; $display("FAIL ovf_sticky got %h exp 00000006", ReadDataM); end
        drive(1'b1, F3_W, BASE + 32'h8, 32'h0, 1'b0);
        drive(1'b0, F3_W, BASE + 32'h8, 32'h0, 1'b0);
        n_tests++; if (ReadDataM !== 32'h0000_0002) begin n_fail++; $display("FAIL ovf_clear got %h exp 00000002", ReadDataM); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] e8;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, F3_W, BASE + 32'h4, 32'(8'h10 + i), 1'b0);
            tx_q.push_back(8'(8'h10 + i));
        end
        drive(1'b1, F3_W, BASE + 32'h4, 32'h0000_00AA, 1'b1);
        e8 = tx_q.pop_front();
        n_tests++; if (tx_data !== e8) begin n_fail++; $display("FAIL full_pp_head got %h exp %h", tx_data, e8); end
        tx_q.push_back(8'hAA);
        drive(1'b0, F3_W, BASE + 32'h8, 32'h0, 1'b0);
        n_tests++; if (ReadDataM !== 32'h0000_0081) begin n_fail++; $display("FAIL full_pp_stat got %h exp 00000081", ReadDataM); end
        for (int c = 0; c < 20 && tx_q.size() > 0; c++) begin
            drive(1'b0, F3_W, 32'h0, 32'h0, 1'b1);
            if (tx_valid) begin
                e8 = tx_q.pop_front();
                n_tests++;
                if (tx_data !== e8) begin n_fail++; $display("FAIL full_pp_drain got %h exp %h", tx_data, e8); end
            end
        end
        n_tests++; if (tx_q.size() != 0) begin n_fail++; $display("FAIL full_pp_timeout left %0d exp 0", tx_q.size()); end
        drive(1'b0, F3_W, 32'h0, 32'h0, 1'b0);
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL full_pp_empty got %b exp 0", tx_valid); end
    endtask

    task automatic test_cycle();
        logic [31:0] cexp [5] = '{32'h1, 32'h2, 32'hFFFF_FFFF, 32'h0, 32'h1};
        logic [31:0] e;
        drive(1'b1, F3_W, BASE + 32'hC, 32'h0000_DEAD, 1'b0);
        for (int i = 0; i < 5; i++) exp_q.push_back(cexp[i]);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                force dut.cycle = 32'hFFFF_FFFE;
                #1;
                release dut.cycle;
            end
            drive(1'b0, F3_W, BASE + 32'hC, 32'h0, 1'b0);
            e = exp_q.pop_front();
            n_tests++;
            if (ReadDataM !== e) begin n_fail++; $display("FAIL cycle_%0d got %h exp %h", i, ReadDataM, e); end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, F3_W, BASE, 32'hCAFE_F00D, 1'b0);
        for (int i = 0; i < 6; i++)
            drive(1'b1, F3_W, BASE + 32'h4, 32'(8'h60 + i), 1'b0);
        drive(1'b0, F3_W, 32'h2, 32'h0, 1'b1);
        drive(1'b0, F3_W, BASE + 32'h8, 32'h0, 1'b0);
        n_tests++; if (ReadDataM !== 32'h0000_0050) begin n_fail++; $display("FAIL mid_count5 got %h exp 00000050", ReadDataM); end
        n_tests++; if (gpio_out !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mid_gpio got %h exp cafef00d", gpio_out); end
        n_tests++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL mid_err_pre got %b exp 1", mem_err); end
        drive(1'b1, F3_W, BASE, 32'h5555_5555, 1'b1);
        reset = 1'b1;
        drive(1'b0, F3_W, BASE + 32'h8, 32'h0, 1'b0);
        reset = 1'b0;
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", tx_valid); end
        n_tests++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL mid_tx_data got %h exp 0", tx_data); end
        n_tests++; if (ReadDataM !== 32'h0000_0002) begin n_fail++; $display("FAIL mid_txstat got %h exp 00000002", ReadDataM); end
        n_tests++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL mid_gpio_rst got %h exp 0", gpio_out); end
        n_tests++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL mid_err_rst got %b exp 0", mem_err); end
        tx_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        MemWriteM  = 1'b0;
        funct3M    = F3_W;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        tx_ready   = 1'b0;
        test_reset();
        test_ram_loads();
        test_store_steer();
        test_fifo_overflow();
        test_full_push_pop();
        test_cycle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
